pool_fmap_reader: RTL and testbench

//  Receive end of the max-pool/ReLU output stream. Captures one pooled feature
//  map (MAP_WIDTH x MAP_HEIGHT pixels x 3 channels, raster order) from the

---
 rtl/pool_fmap_reader.sv | 111 +++++++++++
 tb/tb_pool_fmap_reader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pool_fmap_reader.sv
// pool_fmap_reader: captures one pooled 3-channel feature map from the pool's
// strobed outputs into a single frame buffer, then replays it over valid/ready.
module pool_fmap_reader #(
    parameter int DATA_BIT   = 12,
    parameter int MAP_WIDTH  = 12,
    parameter int MAP_HEIGHT = 12,
    parameter int ADDR_W     = 8
) (
    input  logic                gclk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                valid_in,
    input  logic [DATA_BIT-1:0] data_in_1,
    input  logic [DATA_BIT-1:0] data_in_2,
    input  logic [DATA_BIT-1:0] data_in_3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_BIT-1:0] out_data_1,
    output logic [DATA_BIT-1:0] out_data_2,
    output logic [DATA_BIT-1:0] out_data_3,
    output logic [3:0]          out_x,
    output logic [3:0]          out_y,
    output logic                out_last,
    output logic                busy,
    output logic                overflow
);
    localparam int N = MAP_WIDTH * MAP_HEIGHT;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
    localparam logic [3:0] X_LAST = 4'(MAP_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t                    state, state_nxt;
    logic [ADDR_W-1:0]         wr_ptr, rd_ptr, rd_nxt;
    logic [3*DATA_BIT-1:0]     mem [2**ADDR_W];
    logic                      wr_en, xfer, load_first;

    always_comb begin
        state_nxt  = state;
        rd_nxt     = rd_ptr + ADDR_W'(1);
        wr_en      = valid_in && !clear && state != DRAIN;
        xfer       = out_valid && out_ready && state == DRAIN;
        load_first = valid_in && state == FILL && wr_ptr == LAST;
        unique case (state)
            IDLE:    state_nxt = valid_in ? FILL : IDLE;
            FILL:    state_nxt = load_first ? DRAIN : FILL;
            DRAIN:   state_nxt = (xfer && rd_ptr == LAST) ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
        if (clear)
            state_nxt = IDLE;
    end

    // wr_ptr is held at 0 whenever the block is idle, so it doubles as the IDLE write address
    always_ff @(posedge gclk)
        if (wr_en)
            mem[wr_ptr] <= {data_in_1, data_in_2, data_in_3};

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            out_valid  <= 1'b0;
            out_data_1 <= '0;
            out_data_2 <= '0;
            out_data_3 <= '0;
            out_x      <= '0;
            out_y      <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= state_nxt != IDLE;
            if (clear) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                out_x     <= '0;
                out_y     <= '0;
                overflow  <= 1'b0;
            end else begin
                if (valid_in && state == DRAIN)
                    overflow <= 1'b1;
                if (wr_en)
                    wr_ptr <= load_first ? '0 : wr_ptr + ADDR_W'(1);
                if (load_first) begin
                    out_valid <= 1'b1;
                    rd_ptr    <= '0;
                    out_x     <= '0;
                    out_y     <= '0;
                    out_last  <= 1'b0;
                    {out_data_1, out_data_2, out_data_3} <= mem['0];
                end
                if (xfer && rd_ptr == LAST) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    rd_ptr    <= '0;
                end else if (xfer) begin
                    rd_ptr   <= rd_nxt;
                    out_last <= rd_nxt == LAST;
                    out_x    <= (out_x == X_LAST) ? 4'd0 : out_x + 4'd1;
                    out_y    <= (out_x == X_LAST) ? out_y + 4'd1 : out_y;
                    {out_data_1, out_data_2, out_data_3} <= mem[rd_nxt];
                end
            end
        end
    end
endmodule

// File: tb/tb_pool_fmap_reader.sv
// tb_pool_fmap_reader: directed frame sequences with random payloads and ready
// patterns, checked against a per-pixel model of the expected replay.
module tb_pool_fmap_reader;
    localparam int N = 144;
    localparam int W = 12;

    logic        gclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        valid_in = 1'b0;
    logic [11:0] data_in_1 = '0, data_in_2 = '0, data_in_3 = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [11:0] out_data_1, out_data_2, out_data_3;
    logic [3:0]  out_x, out_y;
    logic        out_last, busy, overflow;

    logic [11:0] e1 [N];
    logic [11:0] e2 [N];
    logic [11:0] e3 [N];
    int tests = 0;
    int fails = 0;

    pool_fmap_reader dut (
        .gclk(gclk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in),
        .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data_1(out_data_1), .out_data_2(out_data_2), .out_data_3(out_data_3),
        .out_x(out_x), .out_y(out_y), .out_last(out_last),
        .busy(busy), .overflow(overflow)
    );

    always #5 gclk = ~gclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge gclk);
        #1;
    endtask

    function automatic logic [63:0] exp_px(input int i);
        return {19'b0, e1[i], e2[i], e3[i], 4'(i % W), 4'(i / W), i == N - 1};
    endfunction

    function automatic logic [63:0] obs_px();
        return {19'b0, out_data_1, out_data_2, out_data_3, out_x, out_y, out_last};
    endfunction

    // mode 0: ramp, 1: 1000+i family, 2: random payload
    task automatic fill(input int mode, input int gap, input int count);
        for (int i = 0; i < count; i++) begin
            repeat (gap) step();
            e1[i] = mode == 0 ? 12'(i) : mode == 1 ? 12'(1000 + i) : 12'($urandom_range(0, 4095));
            e2[i] = mode == 0 ? 12'(i + 256) : mode == 1 ? 12'(2000 + i) : 12'($urandom_range(0, 4095));
            e3[i] = mode == 0 ? 12'(4095 - i) : mode == 1 ? 12'(3000 + i) : 12'($urandom_range(0, 4095));
            valid_in = 1'b1;
            data_in_1 = e1[i];
            data_in_2 = e2[i];
            data_in_3 = e3[i];
            step();
            valid_in = 1'b0;
            if (i == N - 2)
                chk("no_early_drain", out_valid, 1'b0);
        end
        if (count == N) begin
            chk("valid_after_last_write", out_valid, 1'b1);
            chk("busy_in_drain", busy, 1'b1);
        end
    endtask

    // mode 0: ready high, 1: 1,0,0,1 pattern with a 5-cycle hold, 2: random ready
    task automatic drain(input int mode);
        int k = 0;
        int cyc = 0;
        logic r;
        logic stall = 1'b0;
        logic [63:0] held = '0;
        while (k < N && cyc < 3000) begin
            r = mode == 0 ? 1'b1 :
                mode == 1 ? ((cyc >= 8 && cyc < 13) ? 1'b0 : (cyc % 4 == 0 || cyc % 4 == 3)) :
                1'($urandom_range(0, 1));
            out_ready = r;
            if (stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_stable", obs_px(), held);
            end
            stall = 1'b0;
            if (out_valid && r) begin
                chk($sformatf("pixel_%0d", k), obs_px(), exp_px(k));
                k++;
            end else if (out_valid) begin
                stall = 1'b1;
                held = obs_px();
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        chk("transfer_count", 64'(k), 64'(N));
        chk("valid_after_drain", out_valid, 1'b0);
        chk("busy_after_drain", busy, 1'b0);
    endtask

    initial begin
        #12;
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle_valid", out_valid, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_overflow", overflow, 1'b0);
        chk("idle_xy_last", {out_x, out_y, out_last}, 9'd0);

        fill(0, 0, N);
        drain(0);

        fill(2, 0, N);
        drain(1);

        fill(2, 2, N);
        drain(0);

        fill(0, 0, N);
        valid_in = 1'b1;
        data_in_1 = 12'hABC;
        data_in_2 = 12'hDEF;
        data_in_3 = 12'h123;
        step();
        valid_in = 1'b0;
        chk("overflow_set", overflow, 1'b1);
        chk("overflow_valid_held", out_valid, 1'b1);
        drain(0);
        chk("overflow_sticky", overflow, 1'b1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_overflow", overflow, 1'b0);
        chk("clear_busy", busy, 1'b0);

        fill(2, 0, 30);
        chk("partial_busy", busy, 1'b1);
        clear = 1'b1;
        valid_in = 1'b1;
        step();
        clear = 1'b0;
        valid_in = 1'b0;
        chk("clear_mid_fill_busy", busy, 1'b0);
        chk("clear_mid_fill_valid", out_valid, 1'b0);
        fill(2, 1, N);
        drain(2);

        fill(2, 0, 50);
        rst_n = 1'b0;
        #2;
        chk("async_reset_busy", busy, 1'b0);
        chk("async_reset_valid", out_valid, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        fill(1, 0, N);
        drain(0);
        chk("final_overflow", overflow, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
